// File: rtl/ps2_key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_key_event_scheduler
//  Purpose  : Turns PS/2 scan bytes (E0/F0 prefixed) into key events, queues
//             them in a small FIFO and serves them to the PicoBlaze port bus
//             with an acknowledged interrupt. Optional macro:
//             KEY_BREAK_EVENTS_EN (queue break events as well as makes).
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_key_event_scheduler #(
    parameter int         DEPTH_LOG2  = 3,
    parameter logic [7:0] DATA_PORT   = 8'h02,
    parameter logic [7:0] STATUS_PORT = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port_data,
    output logic       interrupt,
    output logic       rx_en
);

    localparam int                  c_DEPTH_N = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH   = (DEPTH_LOG2+1)'(c_DEPTH_N);
    localparam logic [DEPTH_LOG2:0] c_CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [7:0]          c_EXT_BYTE = 8'hE0;
    localparam logic [7:0]          c_BRK_BYTE = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                  w_offer;
    logic                  w_ev_brk;
    logic                  w_ev_ext;
    logic [9:0]            w_entry;

    logic [9:0]            r_mem [0:c_DEPTH_N-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   w_count_next;
    logic                  r_overflow;
    logic                  r_interrupt;
    logic                  r_armed;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_status_rd;
    logic                  w_irq_set;
    logic [9:0]            w_head;
    logic                  w_head_brk;
    logic                  w_head_ext;
    logic [3:0]            w_count4;

    // ---------------- prefix decoder ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_offer      = 1'b0;
        w_ev_brk     = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
        w_ev_ext     = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
        if (rx_done_tick) begin
            if (rx_data == c_EXT_BYTE) begin
                // E0 always restarts an extended sequence, dropping a stray break
                w_state_next = ST_EXT;
            end else if (rx_data == c_BRK_BYTE) begin
                if (r_state == ST_IDLE) begin
                    w_state_next = ST_BRK;
                end else if (r_state == ST_EXT) begin
                    w_state_next = ST_EXT_BRK;
                end
            end else begin
`ifdef KEY_BREAK_EVENTS_EN
                w_offer = 1'b1;
`else
                w_offer = !w_ev_brk;
`endif
                w_state_next = ST_IDLE;
            end
        end
    end

`ifdef KEY_BREAK_EVENTS_EN
    assign w_entry = {w_ev_brk, w_ev_ext, rx_data};
`else
    assign w_entry = {1'b0, w_ev_ext, rx_data};
`endif

    // ---------------- event FIFO ----------------
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_DEPTH);
    assign w_pop       = read_strobe && (port_id == DATA_PORT) && !w_empty;
    assign w_push      = w_offer && (!w_full || w_pop);
    assign w_drop      = w_offer && w_full && !w_pop;
    assign w_status_rd = read_strobe && (port_id == STATUS_PORT);

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + c_CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (w_status_rd) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ---------------- interrupt handshake ----------------
    // Ack takes priority over a new request; armed stays set so it retries.
    assign w_irq_set = r_armed && (w_count_next != '0) && !interrupt_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_interrupt <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            if (interrupt_ack) begin
                r_interrupt <= 1'b0;
            end else if (w_irq_set) begin
                r_interrupt <= 1'b1;
            end
            if (w_irq_set) begin
                r_armed <= 1'b0;
            end else if (w_pop) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ---------------- port read mux ----------------
    assign w_head     = r_mem[r_rd_ptr];
    assign w_head_brk = w_head[9] && !w_empty;
    assign w_head_ext = w_head[8] && !w_empty;
    assign w_count4   = 4'(r_count);

    always_comb begin
        in_port_data = 8'h00;
        if (port_id == DATA_PORT) begin
            in_port_data = w_empty ? 8'h00 : w_head[7:0];
        end else if (port_id == STATUS_PORT) begin
            in_port_data = {r_overflow, w_head_brk, w_head_ext, w_full, w_count4};
        end
    end

    assign interrupt = r_interrupt;
    assign rx_en     = !w_full;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_event_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_key_event_scheduler
//  Purpose  : Directed scenarios plus randomized traffic against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_event_scheduler;

    localparam logic [7:0] c_DATA_P  = 8'h02;
    localparam logic [7:0] c_STAT_P  = 8'h03;
    localparam logic [7:0] c_OTHER_P = 8'h05;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] port_id = 8'h00;
    logic       read_strobe = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic [7:0] in_port_data;
    logic       interrupt;
    logic       rx_en;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_key_event_scheduler #(
        .DEPTH_LOG2  (3),
        .DATA_PORT   (c_DATA_P),
        .STATUS_PORT (c_STAT_P)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_done_tick  (rx_done_tick),
        .rx_data       (rx_data),
        .port_id       (port_id),
        .read_strobe   (read_strobe),
        .interrupt_ack (interrupt_ack),
        .in_port_data  (in_port_data),
        .interrupt     (interrupt),
        .rx_en         (rx_en)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data      = b;
        rx_done_tick = 1'b1;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic peek(input logic [7:0] p, output logic [7:0] v);
        port_id = p;
        #1;
        v = in_port_data;
    endtask

    task automatic read_port(input logic [7:0] p, output logic [7:0] v);
        port_id     = p;
        read_strobe = 1'b1;
        #1;
        v = in_port_data;
        @(posedge clk);
        #1;
        read_strobe = 1'b0;
    endtask

    task automatic ack_pulse();
        interrupt_ack = 1'b1;
        @(posedge clk);
        #1;
        interrupt_ack = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        logic [7:0] v;
        do_reset();
        n_checks++;
        if (interrupt !== 1'b0) $display("FAIL reset_irq: got %b expected 0", interrupt);
        else n_pass++;
        n_checks++;
        if (rx_en !== 1'b1) $display("FAIL reset_rx_en: got %b expected 1", rx_en);
        else n_pass++;
        peek(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL reset_data: got %h expected 00", v);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL reset_status: got %h expected 00", v);
        else n_pass++;
        peek(c_OTHER_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL reset_other_port: got %h expected 00", v);
        else n_pass++;
    endtask

    task automatic test_make();
        logic [7:0] v;
        do_reset();
        send_byte(8'h1C);
        n_checks++;
        if (interrupt !== 1'b1) $display("FAIL make_irq: got %b expected 1", interrupt);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h01) $display("FAIL make_status: got %h expected 01", v);
        else n_pass++;
        read_port(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h1C) $display("FAIL make_data: got %h expected 1c", v);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL make_status_after: got %h expected 00", v);
        else n_pass++;
        read_port(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL make_empty_read: got %h expected 00", v);
        else n_pass++;
    endtask

    task automatic test_ext_break();
        logic [7:0] v;
        do_reset();
        send_byte(8'hE0);
        send_byte(8'hF0);
        n_checks++;
        if (interrupt !== 1'b0) $display("FAIL prefix_no_push_irq: got %b expected 0", interrupt);
        else n_pass++;
        send_byte(8'h75);
`ifdef KEY_BREAK_EVENTS_EN
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h61) $display("FAIL ext_break_status: got %h expected 61", v);
        else n_pass++;
        read_port(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h75) $display("FAIL ext_break_data: got %h expected 75", v);
        else n_pass++;
`else
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL ext_break_status: got %h expected 00", v);
        else n_pass++;
        n_checks++;
        if (interrupt !== 1'b0) $display("FAIL ext_break_irq: got %b expected 0", interrupt);
        else n_pass++;
`endif
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        do_reset();
        for (int i = 1; i <= 9; i++) send_byte(8'(i));
        n_checks++;
        if (rx_en !== 1'b0) $display("FAIL ovf_rx_en: got %b expected 0", rx_en);
        else n_pass++;
        read_port(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h98) $display("FAIL ovf_status: got %h expected 98", v);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h18) $display("FAIL ovf_cleared: got %h expected 18", v);
        else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            read_port(c_DATA_P, v);
            n_checks++;
            if (v !== 8'(i)) $display("FAIL ovf_data_%0d: got %h expected %h", i, v, 8'(i));
            else n_pass++;
        end
        n_checks++;
        if (rx_en !== 1'b1) $display("FAIL ovf_rx_en_back: got %b expected 1", rx_en);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h00) $display("FAIL ovf_drained: got %h expected 00", v);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        rx_data      = 8'h55;
        rx_done_tick = 1'b1;
        port_id      = c_DATA_P;
        read_strobe  = 1'b1;
        #1;
        v = in_port_data;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        read_strobe  = 1'b0;
        n_checks++;
        if (v !== 8'h01) $display("FAIL b2b_pop_data: got %h expected 01", v);
        else n_pass++;
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h18) $display("FAIL b2b_status: got %h expected 18", v);
        else n_pass++;
        for (int i = 2; i <= 9; i++) begin
            read_port(c_DATA_P, v);
            n_checks++;
            if (v !== ((i == 9) ? 8'h55 : 8'(i)))
                $display("FAIL b2b_order_%0d: got %h expected %h", i, v, (i == 9) ? 8'h55 : 8'(i));
            else n_pass++;
        end
    endtask

    task automatic test_interrupt();
        logic [7:0] v;
        do_reset();
        send_byte(8'h11);
        send_byte(8'h22);
        n_checks++;
        if (interrupt !== 1'b1) $display("FAIL irq_raise: got %b expected 1", interrupt);
        else n_pass++;
        ack_pulse();
        n_checks++;
        if (interrupt !== 1'b0) $display("FAIL irq_ack: got %b expected 0", interrupt);
        else n_pass++;
        idle(3);
        n_checks++;
        if (interrupt !== 1'b0) $display("FAIL irq_stays_low: got %b expected 0", interrupt);
        else n_pass++;
        read_port(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h11) $display("FAIL irq_read: got %h expected 11", v);
        else n_pass++;
        idle(1);
        n_checks++;
        if (interrupt !== 1'b1) $display("FAIL irq_rearm: got %b expected 1", interrupt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_prefix();
        logic [7:0] v;
        do_reset();
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h1C);
        peek(c_STAT_P, v);
        n_checks++;
        if (v !== 8'h01) $display("FAIL midreset_status: got %h expected 01", v);
        else n_pass++;
        read_port(c_DATA_P, v);
        n_checks++;
        if (v !== 8'h1C) $display("FAIL midreset_data: got %h expected 1c", v);
        else n_pass++;
    endtask

    // ---------------- randomized traffic vs queue model ----------------
    task automatic test_random();
        logic [9:0] q[$];
        logic [9:0] ev;
        logic [9:0] head;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] exp_v;
        bit         m_ext, m_brk, m_ovf, tick, rd, pop, offer, drop;
        int         sel;
        do_reset();
        q.delete();
        m_ext = 0; m_brk = 0; m_ovf = 0;
        for (int it = 0; it < 400; it++) begin
            tick = ($urandom % 2) == 1;
            sel  = int'($urandom % 8);
            b    = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(1, 127));
            rd   = ($urandom % 3) == 0;
            sel  = int'($urandom % 3);
            p    = (sel == 0) ? c_DATA_P : (sel == 1) ? c_STAT_P : c_OTHER_P;
            rx_data = b; rx_done_tick = tick; port_id = p; read_strobe = rd;
            #1;
            head = (q.size() > 0) ? q[0] : 10'h000;
            if (p == c_DATA_P) exp_v = head[7:0];
            else if (p == c_STAT_P) exp_v = {m_ovf, head[9], head[8], q.size() == 8, 4'(q.size())};
            else exp_v = 8'h00;
            n_checks++;
            if (in_port_data !== exp_v)
                $display("FAIL rand_read_%0d: port %h got %h expected %h", it, p, in_port_data, exp_v);
            else n_pass++;
            n_checks++;
            if (rx_en !== (q.size() < 8))
                $display("FAIL rand_rx_en_%0d: got %b expected %b", it, rx_en, q.size() < 8);
            else n_pass++;
            @(posedge clk);
            #1;
            rx_done_tick = 1'b0;
            read_strobe  = 1'b0;
            pop   = rd && (p == c_DATA_P) && (q.size() > 0);
            offer = 0;
            ev    = 10'h000;
            if (tick) begin
                if (b == 8'hE0) begin
                    m_ext = 1; m_brk = 0;
                end else if (b == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    ev = {m_brk, m_ext, b};
`ifdef KEY_BREAK_EVENTS_EN
                    offer = 1;
`else
                    offer = !m_brk;
`endif
                    m_ext = 0; m_brk = 0;
                end
            end
            if (pop) void'(q.pop_front());
            drop = 0;
            if (offer) begin
                if (q.size() < 8) q.push_back(ev);
                else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (rd && p == c_STAT_P) m_ovf = 0;
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_overflow();
        test_back_to_back();
        test_interrupt();
        test_reset_mid_prefix();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
